// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver. It synchronises and filters the PS/2 clock, checks each frame,
// and buffers good bytes in a first-word-fall-through FIFO with a valid/ready read port.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2d,
  input  logic                          ps2c,
  input  logic                          rx_en,
  output logic [7:0]                    dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic                  ps2c_meta_q, ps2c_sync_q;
  logic                  ps2d_meta_q, ps2d_sync_q;
  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  f_ps2c_q, f_ps2c_d;
  logic                  fall_edge;

  logic [1:0]            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [9:0]            shift_q, shift_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  logic [7:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_en, pop, full, frame_good;

  // Filtered clock only changes once the whole window agrees, so short glitches are absorbed
  always_comb begin
    filter_d = {filter_q[FILTER_LEN-2:0], ps2c_sync_q};
    f_ps2c_d = f_ps2c_q;
    if (&filter_q) begin
      f_ps2c_d = 1'b1;
    end else if (~|filter_q) begin
      f_ps2c_d = 1'b0;
    end
    fall_edge = f_ps2c_q & ~f_ps2c_d;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    timer_d      = timer_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    wr_en        = 1'b0;

    dout_valid = (count_q != '0);
    pop        = dout_valid & dout_ready;
    full       = (count_q == CW'(FIFO_DEPTH));
    frame_good = (^shift_q[8:0]) & shift_q[9];

    unique case (state_q)
      IDLE: begin
        if (fall_edge && rx_en && !ps2d_sync_q) begin
          bit_cnt_d = '0;
          timer_d   = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_edge) begin
          shift_d   = {ps2d_sync_q, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = CHECK;
          end
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CHECK: begin
        // A pop in this same cycle frees the slot, so a full FIFO can still take the byte
        if (frame_good) begin
          if (!full || pop) begin
            wr_en = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        parity_err_d = ~(^shift_q[8:0]);
        frame_err_d  = ~shift_q[9];
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wr_en) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2c_meta_q  <= 1'b1;
      ps2c_sync_q  <= 1'b1;
      ps2d_meta_q  <= 1'b1;
      ps2d_sync_q  <= 1'b1;
      filter_q     <= '1;
      f_ps2c_q     <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      timer_q      <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      ps2c_meta_q  <= ps2c;
      ps2c_sync_q  <= ps2c_meta_q;
      ps2d_meta_q  <= ps2d;
      ps2d_sync_q  <= ps2d_meta_q;
      filter_q     <= filter_d;
      f_ps2c_q     <= f_ps2c_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      timer_q      <= timer_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= shift_q[7:0];
    end
  end

  assign dout       = dout_valid ? mem[rd_ptr_q] : 8'h00;
  assign count      = count_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on ps2c/ps2d and results are
// compared against hand-computed bytes, counts and pulse timing.
module tb_ps2_rx_fifo;

  localparam int FL    = 4;
  localparam int TO    = 200;
  localparam int DEPTH = 8;
  localparam int HALF  = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2d, ps2c, rx_en, dout_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic [3:0] count;
  logic       parity_err, frame_err, overrun;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int n_perr = 0, n_ferr = 0, n_ovr = 0;

  int         fall_cyc;
  int         pre_count, snap_count;
  logic       snap_valid, snap_perr, snap_ferr, snap_ovr, post_pulse;
  logic [7:0] snap_dout;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (parity_err) n_perr <= n_perr + 1;
      if (frame_err)  n_ferr <= n_ferr + 1;
      if (overrun)    n_ovr  <= n_ovr + 1;
    end
  end

  // One PS/2 bit: data set while clock high, then clock low; optionally snapshot around N+2
  task automatic drive_bit(input logic b, input bit snap, input bit pop_chk);
    ps2c = 1'b1;
    ps2d = b;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    fall_cyc = cyc;
    if (snap) begin
      repeat (FL + 3) @(negedge clk);
      pre_count = int'(count);
      if (pop_chk) dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
      snap_count = int'(count);
      snap_valid = dout_valid;
      snap_dout  = dout;
      snap_perr  = parity_err;
      snap_ferr  = frame_err;
      snap_ovr   = overrun;
      @(negedge clk);
      post_pulse = parity_err | frame_err | overrun;
      repeat (HALF - FL - 5) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit bad_par, input logic stop,
                            input bit pop_chk, input bit drop_en);
    drive_bit(1'b0, 0, 0);
    if (drop_en) rx_en = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(data[i], 0, 0);
    drive_bit(bad_par ? ^data : ~^data, 0, 0);
    drive_bit(stop, 1, pop_chk);
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; dout_ready = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if ({dout, dout_valid, count, parity_err, frame_err, overrun} !== 16'h0) begin
      failed++;
      $display("[TB] FAIL reset_state: got dout=%h v=%b cnt=%0d pe=%b fe=%b ov=%b, expected all 0",
               dout, dout_valid, count, parity_err, frame_err, overrun);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if ({dout, dout_valid, count, parity_err, frame_err, overrun} !== 16'h0 ||
        (n_perr + n_ferr + n_ovr) != 0) begin
      failed++;
      $display("[TB] FAIL reset_release: got dout=%h v=%b cnt=%0d pulses=%0d, expected all 0",
               dout, dout_valid, count, n_perr + n_ferr + n_ovr);
    end
  endtask

  task automatic test_good_frame;
    int p0, f0, o0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h1C, 0, 1'b1, 0, 0);
    tests++;
    if (pre_count != 0) begin
      failed++;
      $display("[TB] FAIL good_latency: count at N+1 got %0d, expected 0", pre_count);
    end
    tests++;
    if (snap_count != 1 || snap_valid !== 1'b1 || snap_dout !== 8'h1C) begin
      failed++;
      $display("[TB] FAIL good_byte: got cnt=%0d v=%b dout=%h, expected 1 1 1c",
               snap_count, snap_valid, snap_dout);
    end
    tests++;
    if (n_perr != p0 || n_ferr != f0 || n_ovr != o0) begin
      failed++;
      $display("[TB] FAIL good_no_err: got pulses pe=%0d fe=%0d ov=%0d, expected 0 0 0",
               n_perr - p0, n_ferr - f0, n_ovr - o0);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    tests++;
    if (dout_valid !== 1'b0 || dout !== 8'h00 || count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL good_pop: got v=%b dout=%h cnt=%0d, expected 0 00 0",
               dout_valid, dout, count);
    end
  endtask

  task automatic test_parity;
    int p0, f0;
    p0 = n_perr; f0 = n_ferr;
    send_frame(8'hF0, 1, 1'b1, 0, 0);
    tests++;
    if (snap_perr !== 1'b1 || snap_ferr !== 1'b0 || post_pulse !== 1'b0 ||
        n_perr - p0 != 1 || n_ferr != f0) begin
      failed++;
      $display("[TB] FAIL parity_pulse: got pe=%b fe=%b after=%b npe=%0d nfe=%0d, expected 1 0 0 1 0",
               snap_perr, snap_ferr, post_pulse, n_perr - p0, n_ferr - f0);
    end
    tests++;
    if (snap_count != 0 || dout_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL parity_nowrite: got cnt=%0d v=%b, expected 0 0", snap_count, dout_valid);
    end
  endtask

  task automatic test_stop;
    int p0, f0;
    p0 = n_perr; f0 = n_ferr;
    send_frame(8'h55, 0, 1'b0, 0, 0);
    tests++;
    if (snap_ferr !== 1'b1 || snap_perr !== 1'b0 || n_ferr - f0 != 1 || n_perr != p0 ||
        snap_count != 0) begin
      failed++;
      $display("[TB] FAIL stop_err: got fe=%b pe=%b nfe=%0d npe=%0d cnt=%0d, expected 1 0 1 0 0",
               snap_ferr, snap_perr, n_ferr - f0, n_perr - p0, snap_count);
    end
  endtask

  task automatic test_timeout;
    int f0, got;
    logic [7:0] d;
    d = 8'h5A;
    f0 = n_ferr;
    got = -1;
    drive_bit(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 0, 0);
    ps2c = 1'b1;
    ps2d = 1'b1;
    for (int k = 0; k < 2 * TO; k++) begin
      @(negedge clk);
      if (frame_err && got < 0) got = cyc;
    end
    tests++;
    if (got != fall_cyc + FL + TO + 3 || n_ferr - f0 != 1) begin
      failed++;
      $display("[TB] FAIL timeout: got cycle %0d (pulses %0d), expected cycle %0d (pulses 1)",
               got, n_ferr - f0, fall_cyc + FL + TO + 3);
    end
    send_frame(8'h1C, 0, 1'b1, 0, 0);
    tests++;
    if (snap_count != 1 || snap_dout !== 8'h1C || snap_ferr !== 1'b0) begin
      failed++;
      $display("[TB] FAIL after_timeout: got cnt=%0d dout=%h fe=%b, expected 1 1c 0",
               snap_count, snap_dout, snap_ferr);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_overrun;
    int o0;
    dout_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      send_frame(8'(i), 0, 1'b1, 0, 0);
      tests++;
      if (snap_count != i || snap_ovr !== 1'b0) begin
        failed++;
        $display("[TB] FAIL fill_%0d: got cnt=%0d ov=%b, expected %0d 0", i, snap_count, snap_ovr, i);
      end
    end
    o0 = n_ovr;
    send_frame(8'(DEPTH + 1), 0, 1'b1, 0, 0);
    tests++;
    if (snap_ovr !== 1'b1 || n_ovr - o0 != 1 || snap_count != DEPTH || snap_dout !== 8'h01) begin
      failed++;
      $display("[TB] FAIL overrun: got ov=%b nov=%0d cnt=%0d head=%h, expected 1 1 %0d 01",
               snap_ovr, n_ovr - o0, snap_count, snap_dout, DEPTH);
    end
    dout_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tests++;
      if (dout !== 8'(i) || dout_valid !== 1'b1 || count !== 4'(DEPTH + 1 - i)) begin
        failed++;
        $display("[TB] FAIL drain_%0d: got dout=%h v=%b cnt=%0d, expected %h 1 %0d",
                 i, dout, dout_valid, count, 8'(i), DEPTH + 1 - i);
      end
      @(negedge clk);
    end
    dout_ready = 1'b0;
    tests++;
    if (dout_valid !== 1'b0 || dout !== 8'h00 || count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL drain_empty: got v=%b dout=%h cnt=%0d, expected 0 00 0",
               dout_valid, dout, count);
    end
  endtask

  task automatic test_full_pop;
    logic [7:0] exp_q[$];
    int o0;
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h11 + 8'(i), 0, 1'b1, 0, 0);
      if (i > 0) exp_q.push_back(8'h11 + 8'(i));
    end
    exp_q.push_back(8'h99);
    o0 = n_ovr;
    send_frame(8'h99, 0, 1'b1, 1, 0);
    tests++;
    if (snap_count != DEPTH || snap_ovr !== 1'b0 || n_ovr != o0 || snap_dout !== 8'h12) begin
      failed++;
      $display("[TB] FAIL full_pop: got cnt=%0d ov=%b nov=%0d head=%h, expected %0d 0 0 12",
               snap_count, snap_ovr, n_ovr - o0, snap_dout, DEPTH);
    end
    dout_ready = 1'b1;
    foreach (exp_q[i]) begin
      tests++;
      if (dout !== exp_q[i] || dout_valid !== 1'b1) begin
        failed++;
        $display("[TB] FAIL full_pop_drain_%0d: got dout=%h v=%b, expected %h 1",
                 i, dout, dout_valid, exp_q[i]);
      end
      @(negedge clk);
    end
    dout_ready = 1'b0;
    tests++;
    if (dout_valid !== 1'b0 || count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL full_pop_empty: got v=%b cnt=%0d, expected 0 0", dout_valid, count);
    end
  endtask

  task automatic test_glitch;
    int f0;
    f0 = n_ferr;
    ps2d = 1'b0;
    ps2c = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2c = 1'b1;
    repeat (TO + 50) @(negedge clk);
    ps2d = 1'b1;
    tests++;
    if (n_ferr != f0 || count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL glitch: got fe pulses=%0d cnt=%0d, expected 0 0", n_ferr - f0, count);
    end
  endtask

  task automatic test_rx_en;
    int p0, f0;
    p0 = n_perr; f0 = n_ferr;
    rx_en = 1'b0;
    send_frame(8'h1C, 0, 1'b1, 0, 0);
    repeat (TO + 20) @(negedge clk);
    tests++;
    if (count !== 4'd0 || n_perr != p0 || n_ferr != f0) begin
      failed++;
      $display("[TB] FAIL rx_en_off: got cnt=%0d pe=%0d fe=%0d, expected 0 0 0",
               count, n_perr - p0, n_ferr - f0);
    end
    rx_en = 1'b1;
    send_frame(8'h3A, 0, 1'b1, 0, 1);
    tests++;
    if (snap_count != 1 || snap_dout !== 8'h3A) begin
      failed++;
      $display("[TB] FAIL rx_en_drop: got cnt=%0d dout=%h, expected 1 3a", snap_count, snap_dout);
    end
    rx_en = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int p0, f0, o0;
    send_frame(8'h1C, 0, 1'b1, 0, 0);
    drive_bit(1'b0, 0, 0);
    drive_bit(1'b1, 0, 0);
    drive_bit(1'b0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (count !== 4'd0 || dout_valid !== 1'b0 || dout !== 8'h00) begin
      failed++;
      $display("[TB] FAIL reset_mid: got cnt=%0d v=%b dout=%h, expected 0 0 00", count, dout_valid, dout);
    end
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    repeat (TO + 50) @(negedge clk);
    tests++;
    if (n_perr != p0 || n_ferr != f0 || n_ovr != o0 || count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL reset_mid_quiet: got pulses=%0d cnt=%0d, expected 0 0",
               (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), count);
    end
    send_frame(8'h2B, 0, 1'b1, 0, 0);
    tests++;
    if (snap_count != 1 || snap_dout !== 8'h2B) begin
      failed++;
      $display("[TB] FAIL reset_recover: got cnt=%0d dout=%h, expected 1 2b", snap_count, snap_dout);
    end
  endtask

  initial begin
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; dout_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_parity();
    test_stop();
    test_timeout();
    test_overrun();
    test_full_pop();
    test_glitch();
    test_rx_en();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver that replaces the single-byte, LED-latching receiver in the keyboard input path. It synchronises and glitch-filters the PS/2 clock, deserialises 11-bit frames and checks the start, parity and stop bits. Good bytes are buffered in a first-word-fall-through FIFO with a valid/ready read port. A watchdog aborts stalled frames, so the scan-code decoder downstream only ever sees checked bytes.

## Interface
- FILTER_LEN, 8: PS/2 clock filter length in cycles, range 2..16.
- TIMEOUT_CYC, 50000: maximum cycles allowed between filtered falling edges inside a frame, at least 2.
- FIFO_DEPTH, 8: number of byte entries; must be a power of two, at least 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2d  in  1  raw PS/2 data line.
- ps2c  in  1  raw PS/2 clock line.
- rx_en  in  1  when low, new frames are not started.
- dout  out  8  FIFO head byte; 8'h00 while the FIFO is empty.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts the head byte.
- count  out  $clog2(FIFO_DEPTH)+1  number of bytes held.
- parity_err  out  1  one-cycle pulse: a frame was dropped for odd-parity failure.
- frame_err  out  1  one-cycle pulse: a frame was dropped for bad stop bit or timeout.
- overrun  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.

## Operation
- ps2c and ps2d each pass through a 2-flop synchroniser.
- Filter:
  - The synchronised ps2c shifts into a FILTER_LEN-bit register.
  - The filtered clock f_ps2c is set when the register is all ones and cleared when it is all zeros; otherwise it holds.
  - Reset loads the register with all ones and f_ps2c=1, so no false edge occurs after reset.
- fall_edge is asserted in the cycle where f_ps2c is 1 and its next value is 0. Synchronised ps2d is sampled in that cycle.
- State machine IDLE / SHIFT / CHECK; reset goes to IDLE.
  - IDLE: on fall_edge with rx_en=1 and sampled data=0, clear the bit counter and timer and go to SHIFT. A sampled 1, or rx_en=0, stays in IDLE with no error.
  - SHIFT:
    - Each fall_edge shifts the data bit into a 10-bit register, LSB first (d0..d7, parity, stop).
    - After the 10th bit, go to CHECK.
    - rx_en is ignored; a started frame always completes or times out.
  - CHECK lasts exactly one cycle, then returns to IDLE.
    - The frame is good when the XOR of d7..d0 and the parity bit is 1 and stop=1.
    - Good byte: FIFO write if the FIFO is not full or a pop occurs in the same cycle; otherwise overrun.
    - Parity failure gives parity_err. Stop=0 gives frame_err. If both fail, both pulse. No write in either case.
- Timer:
  - Cleared on every fall_edge and counts cycles only in SHIFT.
  - On reaching TIMEOUT_CYC-1 in SHIFT, the partial frame is discarded, frame_err pulses and the FSM returns to IDLE.
- FIFO:
  - Pop occurs when dout_valid=1 and dout_ready=1. dout_ready is ignored while empty.
  - Pointers wrap modulo FIFO_DEPTH; count is the true occupancy, 0..FIFO_DEPTH.
  - A simultaneous write and pop leaves count unchanged.

## Timing
- Reset values:
  - dout=0, dout_valid=0, count=0; parity_err, frame_err and overrun all 0.
  - FSM in IDLE, FIFO pointers at 0.
- Let the fall_edge that samples the stop bit be cycle N.
  - CHECK is cycle N+1.
  - The FIFO write and the error/overrun pulses are all registered. dout_valid, dout, count and any pulse are visible in N+2, each pulse lasting one cycle.
- Raw ps2c falling to fall_edge: 2 synchroniser cycles plus FILTER_LEN cycles.
- Timeout: frame_err is visible 1 cycle after the timer reaches TIMEOUT_CYC-1; the FSM is in IDLE in the same cycle.
- Pop: dout shows the next entry, or 0 if the FIFO became empty, in the cycle after the accepting edge. count decrements in that same cycle.
- A reset asserted mid-frame or with data in the FIFO clears everything immediately. No pulse is generated on reset release.

## Test plan
- Reset, then send frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1 in line order) at a 60-cycle half period -> dout=8'h1C, dout_valid=1, count=1 at N+2; no error pulses.
- Send 0xF0 with parity 0 (wrong) -> a single parity_err pulse, count unchanged at 0, dout_valid=0.
- Send 0x55 with stop=0 -> frame_err pulse, no write. Separately, stop ps2c toggling after the 4th bit -> frame_err exactly TIMEOUT_CYC cycles after the last edge, FSM back in IDLE. A following valid 0x1C is then received correctly.
- dout_ready=0; send FIFO_DEPTH+1 frames 0x01, 0x02, ... -> count=FIFO_DEPTH, overrun pulses once on the last frame. Then hold dout_ready=1 -> bytes 0x01..0x08 in order, then dout_valid=0 and dout=0.
- FIFO full with dout_ready=1 held during a frame's CHECK cycle -> write accepted, count stays FIFO_DEPTH, no overrun.
- A ps2c glitch shorter than FILTER_LEN cycles produces no fall_edge. A frame started with rx_en=1 and rx_en dropped mid-frame still delivers its byte. Asserting reset mid-frame gives count=0 and no pulses.
